// File: rtl/pattern_sequencer.sv
// Pattern sequencer: a bank of NO_BUFS pattern buffers, each holding a P and an
// N group of drive/sense/delay/tweak fields. On every PWM edge the outputs go
// safe for a programmable dead time, then the buffers of the active group are
// stepped out one per cycle. A registered host port reads and writes any field.
module pattern_sequencer #(
  parameter int BUFFER_WIDTH = 8,
  parameter int NO_BUFS      = 8,
  parameter int NO_TWEAKS    = 8,
  parameter int DEAD_BITS    = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pwm,
  input  logic [DEAD_BITS-1:0]              dead_cycles,
  input  logic                              wrap_mode,
  input  logic [3:0]                        bufp_in,
  input  logic [4:0]                        fieldp_in,
  input  logic [4:0]                        fieldwp_in,
  input  logic [BUFFER_WIDTH-1:0]           field_in_in,
  input  logic                              field_write_in,
  output logic [BUFFER_WIDTH-1:0]           field_byte_out,
  output logic [BUFFER_WIDTH-1:0]           p_drive,
  output logic [BUFFER_WIDTH-1:0]           n_drive,
  output logic [BUFFER_WIDTH-1:0]           tweak_sense,
  output logic [BUFFER_WIDTH-1:0]           tweak_delay,
  output logic [NO_TWEAKS*BUFFER_WIDTH-1:0] tweak_drive,
  output logic                              dead_time,
  output logic [3:0]                        buf_index
);

  localparam int HALF      = 3 + NO_TWEAKS;
  localparam int NO_FIELDS = 2 * HALF;
  localparam int DEPTH     = NO_BUFS * NO_FIELDS;
  localparam int AW        = $clog2(DEPTH);
  localparam logic [3:0] LAST_BUF = 4'(NO_BUFS - 1);

  // Registered host port
  logic [3:0]              bufp_q;
  logic [4:0]              fieldp_q, fieldwp_q;
  logic [BUFFER_WIDTH-1:0] wdata_q;
  logic                    wr_q;

  // Sequencer state
  logic                    pwm_prev_q;
  logic                    dead_time_q;
  logic [DEAD_BITS-1:0]    dead_cnt_q;
  logic [3:0]              buf_index_q;

  // Storage, read data and registered drive outputs
  logic [BUFFER_WIDTH-1:0]           mem_q [DEPTH];
  logic [BUFFER_WIDTH-1:0]           rd_data_q;
  logic [BUFFER_WIDTH-1:0]           p_drive_q, n_drive_q, sense_q, delay_q;
  logic [NO_TWEAKS*BUFFER_WIDTH-1:0] tweak_q;

  // Flat addresses; out-of-range indices are blocked before they reach storage.
  logic          rd_ok, wr_ok, pwm_event;
  logic [AW-1:0] rd_addr, wr_addr, drv_base;

  assign rd_ok   = (int'(bufp_q) < NO_BUFS) && (int'(fieldp_q) < NO_FIELDS);
  assign wr_ok   = (int'(bufp_q) < NO_BUFS) && (int'(fieldwp_q) < NO_FIELDS);
  assign rd_addr = rd_ok ? AW'(int'(bufp_q) * NO_FIELDS + int'(fieldp_q))  : '0;
  assign wr_addr = wr_ok ? AW'(int'(bufp_q) * NO_FIELDS + int'(fieldwp_q)) : '0;
  // Base of the group being driven: P group in the high phase, N group in the low.
  assign drv_base = AW'(int'(buf_index_q) * NO_FIELDS + (pwm_prev_q ? 0 : HALF));
  // Reset is treated as a permanent PWM edge so release starts a fresh dead time.
  assign pwm_event = (pwm != pwm_prev_q) || !reset;

  // Capture host inputs once
  // NOTE: every clocked block uses non-blocking assignments so all flops
  // sample pre-edge values and simulation matches the synthesized netlist.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bufp_q    <= '0;
      fieldp_q  <= '0;
      fieldwp_q <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
    end else begin
      bufp_q    <= bufp_in;
      fieldp_q  <= fieldp_in;
      fieldwp_q <= fieldwp_in;
      wdata_q   <= field_in_in;
      wr_q      <= field_write_in;
    end
  end

  // Pattern storage: cleared under reset, written one edge after the registered strobe
  // NOTE: the storage is deliberately reset so a reset always leaves known,
  // safe patterns; this costs a clear path on every field register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_q && wr_ok) begin
      mem_q[wr_addr] <= wdata_q;
    end
  end

  // Host read data, zero for out-of-range indices
  always_ff @(posedge clk) begin
    if (!reset)     rd_data_q <= '0;
    else if (rd_ok) rd_data_q <= mem_q[rd_addr];
    else            rd_data_q <= '0;
  end

  // Dead-time counter and buffer stepping
  always_ff @(posedge clk) begin
    pwm_prev_q <= pwm;
    if (pwm_event) begin
      dead_time_q <= 1'b1;
      dead_cnt_q  <= dead_cycles;
      if (!reset) buf_index_q <= '0;
    end else if (dead_time_q) begin
      if (dead_cnt_q != '0) begin
        dead_cnt_q <= dead_cnt_q - DEAD_BITS'(1);
      end else begin
        dead_time_q <= 1'b0;
        buf_index_q <= '0;
      end
    end else if (buf_index_q == LAST_BUF) begin
      buf_index_q <= wrap_mode ? 4'd0 : LAST_BUF;
    end else begin
      buf_index_q <= buf_index_q + 4'd1;
    end
  end

  // Drive outputs from last cycle's state: safe in reset/dead time, else the active group
  always_ff @(posedge clk) begin
    if (!reset || dead_time_q) begin
      p_drive_q <= '1;
      n_drive_q <= '0;
      sense_q   <= '0;
      delay_q   <= '0;
      tweak_q   <= '0;
    end else begin
      p_drive_q <= pwm_prev_q ? mem_q[drv_base] : '1;
      n_drive_q <= pwm_prev_q ? '0 : mem_q[drv_base];
      sense_q   <= mem_q[drv_base + AW'(1)];
      delay_q   <= mem_q[drv_base + AW'(2)];
      for (int i = 0; i < NO_TWEAKS; i++)
        tweak_q[i*BUFFER_WIDTH +: BUFFER_WIDTH] <= mem_q[drv_base + AW'(3 + i)];
    end
  end

  assign field_byte_out = rd_data_q;
  assign p_drive        = p_drive_q;
  assign n_drive        = n_drive_q;
  assign tweak_sense    = sense_q;
  assign tweak_delay    = delay_q;
  assign tweak_drive    = tweak_q;
  assign dead_time      = dead_time_q;
  assign buf_index      = buf_index_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with default parameters (8 buffers,
// 8 tweaks, 22 fields). Inputs change and outputs are sampled on the falling edge.
module tb_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset, pwm, wrap_mode, field_write_in;
  logic [3:0]  dead_cycles, bufp_in, buf_index;
  logic [4:0]  fieldp_in, fieldwp_in;
  logic [7:0]  field_in_in, field_byte_out, p_drive, n_drive, tweak_sense, tweak_delay;
  logic [63:0] tweak_drive;
  logic        dead_time;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pattern_sequencer dut (
    .clk(clk), .reset(reset), .pwm(pwm), .dead_cycles(dead_cycles),
    .wrap_mode(wrap_mode), .bufp_in(bufp_in), .fieldp_in(fieldp_in),
    .fieldwp_in(fieldwp_in), .field_in_in(field_in_in),
    .field_write_in(field_write_in), .field_byte_out(field_byte_out),
    .p_drive(p_drive), .n_drive(n_drive), .tweak_sense(tweak_sense),
    .tweak_delay(tweak_delay), .tweak_drive(tweak_drive),
    .dead_time(dead_time), .buf_index(buf_index)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_safe(input string tag);
    check({tag, "_p"}, 64'(p_drive), 64'hFF);
    check({tag, "_n"}, 64'(n_drive), 64'h00);
    check({tag, "_tw"}, tweak_drive, 64'h0);
  endtask

  task automatic wr(input logic [3:0] b, input logic [4:0] f, input logic [7:0] d);
    bufp_in = b; fieldwp_in = f; field_in_in = d; field_write_in = 1'b1;
    tick();
  endtask

  task automatic wr_flush();
    field_write_in = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b0; pwm = 1'b0; dead_cycles = 4'd3; wrap_mode = 1'b1;
    bufp_in = '0; fieldp_in = '0; fieldwp_in = '0; field_in_in = '0; field_write_in = 1'b0;
    @(negedge clk);
    tick(); tick(); tick();

    // Reset state
    check_safe("rst");
    check("rst_dead", 64'(dead_time), 64'd1);
    check("rst_buf", 64'(buf_index), 64'd0);
    check("rst_rd", 64'(field_byte_out), 64'd0);
    reset = 1'b1;
    tick();

    // Write/read back with 2-edge latency, out-of-range reads return 0
    wr(4'd2, 5'd0, 8'h5A);
    wr_flush();
    bufp_in = 4'd15; fieldp_in = 5'd0;
    tick(); tick();
    check("rd_oob_buf", 64'(field_byte_out), 64'h00);
    bufp_in = 4'd2; fieldp_in = 5'd0;
    tick();
    check("rd_lat1", 64'(field_byte_out), 64'h00);
    tick();
    check("rd_lat2", 64'(field_byte_out), 64'h5A);
    bufp_in = 4'd2; fieldp_in = 5'd22;
    tick(); tick();
    check("rd_oob_fld", 64'(field_byte_out), 64'h00);

    // Load P drive=k, P sense=0x20+k, P tweak7=0x70+k, N drive=0x10+k
    for (int k = 0; k < 8; k++) begin
      wr(4'(k), 5'd0,  8'(k));
      wr(4'(k), 5'd1,  8'(8'h20 + k));
      wr(4'(k), 5'd10, 8'(8'h70 + k));
      wr(4'(k), 5'd11, 8'(8'h10 + k));
    end
    wr_flush();

    // High phase, dead_cycles=3, wrap: 4 safe edges then 0..7,0..3
    pwm = 1'b1;
    tick();
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j <= 4) begin
        check_safe("hi_dead");
        if (j == 3) check("hi_dt3", 64'(dead_time), 64'd1);
        if (j == 4) check("hi_dt4", 64'(dead_time), 64'd0);
      end else begin
        check("hi_p", 64'(p_drive), 64'((j - 5) % 8));
        check("hi_n", 64'(n_drive), 64'h00);
        if (j == 7) begin
          check("hi_sense", 64'(tweak_sense), 64'h22);
          check("hi_tw7", 64'(tweak_drive[63:56]), 64'h72);
        end
      end
    end

    // Low phase, saturate: 4 safe edges then N drive 0x10..0x17, holding 0x17
    wrap_mode = 1'b0;
    pwm = 1'b0;
    tick();
    for (int j = 1; j <= 16; j++) begin
      tick();
      if (j <= 4) check_safe("lo_dead");
      else begin
        check("lo_n", 64'(n_drive), 64'(8'h10 + ((j - 5) > 7 ? 7 : (j - 5))));
        check("lo_p", 64'(p_drive), 64'hFF);
      end
    end
    check("lo_sat_idx", 64'(buf_index), 64'd7);

    // Write to the buffer being driven: old value at the storage edge, new one after
    wr(4'd7, 5'd11, 8'hA5);
    field_write_in = 1'b0;
    tick();
    check("wr_live_old", 64'(n_drive), 64'h17);
    tick();
    check("wr_live_new", 64'(n_drive), 64'hA5);

    // Second toggle inside dead time restarts the 6-cycle dead window
    dead_cycles = 4'd5;
    pwm = 1'b1;
    tick(); tick(); tick();
    pwm = 1'b0;
    tick();
    for (int j = 1; j <= 10; j++) begin
      tick();
      if (j <= 6) begin
        check_safe("rs_dead");
        if (j == 5) check("rs_dt5", 64'(dead_time), 64'd1);
        if (j == 6) check("rs_dt6", 64'(dead_time), 64'd0);
      end else begin
        check("rs_n", 64'(n_drive), 64'(8'h10 + (j - 7)));
      end
    end

    // One-cycle reset mid-sequence
    dead_cycles = 4'd2;
    reset = 1'b0;
    tick();
    check_safe("mr");
    check("mr_dead", 64'(dead_time), 64'd1);
    check("mr_buf", 64'(buf_index), 64'd0);
    reset = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      tick();
      if (j <= 3) check_safe("mr_hold");
      if (j == 2) check("mr_dt2", 64'(dead_time), 64'd1);
      if (j == 3) check("mr_dt3", 64'(dead_time), 64'd0);
      if (j == 4) begin
        check("mr_buf4", 64'(buf_index), 64'd1);
        check("mr_n4", 64'(n_drive), 64'h00);
      end
    end
    bufp_in = 4'd7; fieldp_in = 5'd11;
    tick(); tick();
    check("mr_rd", 64'(field_byte_out), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
